// File: rtl/alu_serial.sv
// Bit-serial ALU: operand-invert-then-operate datapath applied SLICE bits per
// clock, LSB first, with a registered carry between slices. Operands enter and
// results leave through valid/ready handshakes; carry, overflow and zero flags
// are produced on the final slice.
module alu_serial #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             inv_a,
    input  logic             inv_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);
    localparam int STEPS = WIDTH / SLICE;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    localparam logic [1:0]    OP_ADD = 2'b00;
    localparam logic [1:0]    OP_XOR = 2'b01;
    localparam logic [1:0]    OP_AND = 2'b10;
    localparam logic [CW-1:0] LAST   = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_reg, state_next;

    // Latched command and shifting operands
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [1:0]       op_reg;
    logic             inv_a_reg, inv_b_reg;

    // Running datapath state
    logic             carry_reg;
    logic             zacc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_out_reg, overflow_reg, zero_reg;

    // Slice datapath
    logic             accept;
    logic             is_add;
    logic [SLICE-1:0] a_slice, b_slice, slice_res;
    logic [SLICE:0]   chain;
    logic [WIDTH-1:0] slice_ext, result_shift;

    assign accept = in_valid && (state_reg == IDLE);
    assign is_add = (op_reg == OP_ADD);

    // Per-bit invert, ripple carry and operation select across the slice
    assign chain[0] = carry_reg;
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_bit
        assign a_slice[gi]  = a_reg[gi] ^ inv_a_reg;
        assign b_slice[gi]  = b_reg[gi] ^ inv_b_reg;
        assign chain[gi+1]  = (a_slice[gi] & b_slice[gi]) |
                              (chain[gi] & (a_slice[gi] ^ b_slice[gi]));
        assign slice_res[gi] = (op_reg == OP_ADD) ? (a_slice[gi] ^ b_slice[gi] ^ chain[gi]) :
                               (op_reg == OP_XOR) ? (a_slice[gi] ^ b_slice[gi]) :
                               (op_reg == OP_AND) ? (a_slice[gi] & b_slice[gi]) :
                                                    (a_slice[gi] | b_slice[gi]);
    end

    // New slice enters the result register from the top so that after STEPS
    // shifts the first (LSB) slice has reached bit 0.
    assign slice_ext    = WIDTH'(slice_res);
    assign result_shift = (result_reg >> SLICE) | (slice_ext << (WIDTH - SLICE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Command latch, slice stepping and final flag capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_ADD;
            inv_a_reg     <= 1'b0;
            inv_b_reg     <= 1'b0;
            carry_reg     <= 1'b0;
            zacc_reg      <= 1'b0;
            cnt_reg       <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            inv_a_reg <= inv_a;
            inv_b_reg <= inv_b;
            carry_reg <= (op == OP_ADD) & cin;
            zacc_reg  <= 1'b1;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg      <= a_reg >> SLICE;
            b_reg      <= b_reg >> SLICE;
            result_reg <= result_shift;
            carry_reg  <= is_add & chain[SLICE];
            zacc_reg   <= zacc_reg & ~(|slice_res);
            cnt_reg    <= cnt_reg + CW'(1);
            if (cnt_reg == LAST) begin
                carry_out_reg <= is_add & chain[SLICE];
                overflow_reg  <= is_add & (chain[SLICE-1] ^ chain[SLICE]);
                zero_reg      <= zacc_reg & ~(|slice_res);
            end
        end
    end

    assign result    = result_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule
